sw_user_logic: RTL and testbench

- Read-side companion to the LED write logic: samples 8 board switches and returns them to the CPU through the AXI-Lite slave read path.
- Synchronises and debounces the switch inputs, keeps a clear-on-read change mask, and keeps a Gray-coded change-event counter.
- PetaLinux user space polls the counter to detect new activity without tearing.
- Sits beside the LED logic inside the AXI slave; the slave's own read-mux feeds it slv_reg_rden and axi_araddr.

---
 rtl/sw_pkg.sv | 21 ++
 rtl/sw_debounce.sv | 66 ++++++
 rtl/sw_user_logic.sv | 125 ++++++++++++
 tb/tb_sw_user_logic.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// sw_pkg: shared constants and helpers for the switch read-side logic.
//   - Register word indices decoded from axi_araddr / axi_awaddr.
//   - Fixed ID/version word returned at ADDR_ID.
//   - bin2gray: binary to reflected Gray code conversion (32-bit, callers
//     truncate to their counter width; the low bits are width-independent).
package sw_pkg;

  localparam logic [2:0] ADDR_SW   = 3'd0;
  localparam logic [2:0] ADDR_CHG  = 3'd1;
  localparam logic [2:0] ADDR_GRAY = 3'd2;
  localparam logic [2:0] ADDR_ID   = 3'd3;
  localparam logic [2:0] ADDR_IRQ  = 3'd5;

  // "SW" in ASCII, version 01, 8 switches.
  localparam logic [31:0] ID_VALUE = 32'h5357_0108;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser plus shared-counter debouncer for an
// 8-bit switch vector.
// Ports:
//   clk       - sole clock
//   rst       - synchronous, active-high reset
//   sw_raw    - asynchronous switch inputs
//   sw_db     - debounced (committed) switch value
//   commit    - one-cycle pulse, high on the edge sw_db takes a new value
//   new_bits  - bits that change on that commit (sw_db ^ synchronised value),
//               zero when commit is low
// Raw edge to sw_db latency is 2 + DEBOUNCE_CYCLES clock edges.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw_raw,
  output logic [7:0] sw_db,
  output logic       commit,
  output logic [7:0] new_bits
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [7:0]    sw_p1;   // first synchroniser flop
  logic [7:0]    sw_p2;   // second synchroniser flop, the only value debounced
  logic [7:0]    sw_p3;   // sw_p2 one cycle earlier
  logic [CW-1:0] cnt;

  logic pending;
  logic restart;
  logic done;

  // A fresh departure from sw_db (previous value equal to sw_db) counts as
  // the first stable cycle; only a change while already pending restarts.
  assign pending  = (sw_p2 != sw_db);
  assign restart  = (sw_p2 != sw_p3) && (sw_p3 != sw_db);
  assign done     = pending && !restart && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign commit   = done;
  assign new_bits = done ? (sw_db ^ sw_p2) : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_p1 <= 8'h00;
      sw_p2 <= 8'h00;
      sw_p3 <= 8'h00;
      sw_db <= 8'h00;
      cnt   <= '0;
    end else begin
      // stage p1 -> p2 -> p3: synchronise, then remember previous value
      sw_p1 <= sw_raw;
      sw_p2 <= sw_p1;
      sw_p3 <= sw_p2;
      // stage p3 -> commit: stability count and sw_db update
      if (!pending || restart || done) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (done) begin
        sw_db <= sw_p2;
      end
    end
  end

endmodule

// File: rtl/sw_user_logic.sv
// sw_user_logic: read-side switch block living inside the AXI-Lite slave.
// Samples 8 board switches, debounces them, keeps a clear-on-read change
// mask and a Gray-coded change-event counter, and serves them through the
// slave's read strobe with one cycle of latency.
// Ports:
//   S_AXI_ACLK     - sole clock
//   S_AXI_ARESETN  - synchronous reset, active HIGH (reset while 1)
//   slv_reg_rden   - one-cycle read strobe
//   axi_araddr     - register word index of the read
//   SW             - raw asynchronous switch inputs
//   reg_data_out   - registered read data, holds when no read
//   sw_changed     - high while the change mask is non-zero
// Optional build macro SW_IRQ_EN adds:
//   slv_reg_wren, axi_awaddr, S_AXI_WDATA - write path for irq_enable (addr 5)
//   irq            - registered irq_enable & sw_changed
// Register map: 0 sw_db, 1 change mask (clear on read), 2 Gray counter,
// 3 ID 0x53570108, 5 irq_enable (SW_IRQ_EN only), others read 0.
module sw_user_logic
  import sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 16
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        slv_reg_rden,
  input  logic [2:0]  axi_araddr,
  input  logic [7:0]  SW,
`ifdef SW_IRQ_EN
  input  logic        slv_reg_wren,
  input  logic [2:0]  axi_awaddr,
  input  logic [31:0] S_AXI_WDATA,
  output logic        irq,
`endif
  output logic [31:0] reg_data_out,
  output logic        sw_changed
);

  logic             rst;
  logic [7:0]       sw_db;
  logic             commit;
  logic [7:0]       new_bits;
  logic [7:0]       change_mask;
  logic [CNT_W-1:0] bin_cnt;
  logic [CNT_W-1:0] gray_cnt;
  logic [CNT_W-1:0] next_bin;
  logic [31:0]      rd_data;
  logic             rd_chg;

  assign rst = S_AXI_ARESETN;

  sw_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (S_AXI_ACLK),
    .rst      (rst),
    .sw_raw   (SW),
    .sw_db    (sw_db),
    .commit   (commit),
    .new_bits (new_bits)
  );

  assign next_bin   = bin_cnt + CNT_W'(1);
  assign rd_chg     = slv_reg_rden && (axi_araddr == ADDR_CHG);
  assign sw_changed = |change_mask;

`ifdef SW_IRQ_EN
  logic irq_enable;
  logic unused_wdata;

  assign unused_wdata = ^S_AXI_WDATA[31:1];

  always_ff @(posedge S_AXI_ACLK) begin
    if (rst) begin
      irq_enable <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (slv_reg_wren && (axi_awaddr == ADDR_IRQ)) begin
        irq_enable <= S_AXI_WDATA[0];
      end
      irq <= irq_enable & sw_changed;
    end
  end
`endif

  always_comb begin
    rd_data = 32'h0;
    case (axi_araddr)
      ADDR_SW:   rd_data = {24'h0, sw_db};
      ADDR_CHG:  rd_data = {24'h0, change_mask};
      ADDR_GRAY: rd_data = 32'(gray_cnt);
      ADDR_ID:   rd_data = ID_VALUE;
`ifdef SW_IRQ_EN
      ADDR_IRQ:  rd_data = {31'h0, irq_enable};
`endif
      default:   rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (rst) begin
      change_mask  <= 8'h00;
      bin_cnt      <= '0;
      gray_cnt     <= '0;
      reg_data_out <= 32'h0;
    end else begin
      // commit -> mask/counter: a clearing read keeps only bits committed on
      // the same edge, so no event is lost between read and clear
      if (rd_chg) begin
        change_mask <= new_bits;
      end else if (commit) begin
        change_mask <= change_mask | new_bits;
      end
      if (commit) begin
        bin_cnt  <= next_bin;
        gray_cnt <= CNT_W'(bin2gray(32'(next_bin)));
      end
      // read mux -> reg_data_out: returns pre-update state
      if (slv_reg_rden) begin
        reg_data_out <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_sw_user_logic.sv
// Directed testbench for sw_user_logic (DEBOUNCE_CYCLES=4, CNT_W=4).
// When compiled with SW_IRQ_EN it also exercises the irq path.
module tb_sw_user_logic;

  localparam int DEB = 4;
  localparam int CW  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rden;
  logic [2:0]  araddr;
  logic [7:0]  sw;
  logic [31:0] rdata;
  logic        changed;
`ifdef SW_IRQ_EN
  logic        wren;
  logic [2:0]  awaddr;
  logic [31:0] wdata;
  logic        irq;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sw_user_logic #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst),
    .slv_reg_rden  (rden),
    .axi_araddr    (araddr),
    .SW            (sw),
`ifdef SW_IRQ_EN
    .slv_reg_wren  (wren),
    .axi_awaddr    (awaddr),
    .S_AXI_WDATA   (wdata),
    .irq           (irq),
`endif
    .reg_data_out  (rdata),
    .sw_changed    (changed)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    rden   = 1'b1;
    araddr = a;
    tick();
    rden   = 1'b0;
    d      = rdata;
  endtask

`ifdef SW_IRQ_EN
  task automatic wr(input logic [2:0] a, input logic [31:0] v);
    wren   = 1'b1;
    awaddr = a;
    wdata  = v;
    tick();
    wren   = 1'b0;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  gtab [16];
    logic [31:0] d;
    logic [31:0] prev_g;
    int          n;

    gtab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
             4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    n = 0;

    rst    = 1'b1;
    rden   = 1'b0;
    araddr = 3'd0;
    sw     = 8'hFF;
`ifdef SW_IRQ_EN
    wren   = 1'b0;
    awaddr = 3'd0;
    wdata  = 32'h0;
`endif

    // Reset with switches held high
    tick(3);
    check("reset_rdata", rdata, 32'h0);
    check("reset_changed", {31'h0, changed}, 32'h0);
    rst = 1'b0;
    tick(8);
    n = 1;
    rd(3'd0, d); check("post_reset_sw", d, 32'h0000_00FF);
    rd(3'd2, d); check("post_reset_gray", d, 32'h0000_0001);
    check("post_reset_changed", {31'h0, changed}, 32'h1);
    rd(3'd1, d); check("post_reset_mask", d, 32'h0000_00FF);
    rd(3'd1, d); check("post_reset_mask_clr", d, 32'h0);

    // Return to 0 so the bounce test starts from sw_db=0
    sw = 8'h00;
    tick(8);
    n = 2;
    rd(3'd1, d); check("fall_mask", d, 32'h0000_00FF);
    check("pre_bounce_changed", {31'h0, changed}, 32'h0);

    // Bounce: 0x01/0x00 every 2 cycles for 20 cycles, then settle at 0x01
    for (int i = 0; i < 10; i++) begin
      sw = (i % 2 == 0) ? 8'h01 : 8'h00;
      tick(2);
    end
    check("bounce_no_commit", {31'h0, changed}, 32'h0);
    sw = 8'h01;
    tick(5);
    check("settle_edge5", {31'h0, changed}, 32'h0);
    tick(1);
    check("settle_edge6", {31'h0, changed}, 32'h1);
    n = 3;
    rd(3'd2, d); check("bounce_gray", d, {28'h0, gtab[n % 16]});
    rd(3'd0, d); check("bounce_sw", d, 32'h0000_0001);

    // Clear-on-read with a 0x00 -> 0x81 commit
    rd(3'd1, d); check("bounce_mask", d, 32'h0000_0001);
    sw = 8'h00;
    tick(8);
    n = 4;
    rd(3'd1, d); check("to_zero_mask", d, 32'h0000_0001);
    sw = 8'h81;
    tick(8);
    n = 5;
    check("c81_changed", {31'h0, changed}, 32'h1);
    rd(3'd1, d); check("c81_mask", d, 32'h0000_0081);
    check("c81_changed_fall", {31'h0, changed}, 32'h0);
    rd(3'd1, d); check("c81_mask_clr", d, 32'h0);

    // Read of addr1 on the same edge as a commit of bit 4
    sw = 8'h80;
    tick(8);
    n = 6;
    check("pre_sim_changed", {31'h0, changed}, 32'h1);
    sw = 8'h90;
    tick(5);
    rd(3'd1, d); check("sim_read_old", d, 32'h0000_0001);
    n = 7;
    rd(3'd1, d); check("sim_read_new", d, 32'h0000_0010);
    check("sim_changed_clr", {31'h0, changed}, 32'h0);
    rd(3'd0, d); check("sim_sw", d, 32'h0000_0090);
    rd(3'd2, d); check("sim_gray", d, {28'h0, gtab[n % 16]});
    prev_g = d;

    // Gray counter through its 4-bit wrap
    for (int i = 0; i < 11; i++) begin
      sw = (sw == 8'h90) ? 8'h00 : 8'h90;
      tick(8);
      n++;
      rd(3'd2, d);
      check("gray_step", d, {28'h0, gtab[n % 16]});
      check("gray_hamming", $countones(d ^ prev_g), 32'd1);
      prev_g = d;
    end

    // Fixed and unused addresses
    rd(3'd3, d); check("id", d, 32'h5357_0108);
    rd(3'd4, d); check("addr4", d, 32'h0);
    rd(3'd6, d); check("addr6", d, 32'h0);
    rd(3'd7, d); check("addr7", d, 32'h0);
`ifndef SW_IRQ_EN
    rd(3'd5, d); check("addr5_default", d, 32'h0);
`else
    rd(3'd5, d); check("irq_en_reset", d, 32'h0);
    rd(3'd1, d);
    tick(2);
    check("irq_idle", {31'h0, irq}, 32'h0);
    wr(3'd5, 32'h1);
    rd(3'd5, d); check("irq_en_set", d, 32'h1);
    sw = (sw == 8'h90) ? 8'h00 : 8'h90;
    tick(8);
    check("irq_raise", {31'h0, irq}, 32'h1);
    rd(3'd1, d);
    check("irq_hold_1cyc", {31'h0, irq}, 32'h1);
    tick(1);
    check("irq_fall_2cyc", {31'h0, irq}, 32'h0);
    wr(3'd5, 32'h0);
    rd(3'd5, d); check("irq_en_clr", d, 32'h0);
    sw = (sw == 8'h90) ? 8'h00 : 8'h90;
    tick(8);
    check("irq_disabled_changed", {31'h0, changed}, 32'h1);
    check("irq_disabled", {31'h0, irq}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
